// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the MIPS coprocessor-0 block.
//   - default register numbers for Status / Cause / EPC
//   - bit positions of the architected fields inside Status and Cause
//   - register-select decode type and helper
package cp0_pkg;

    localparam int STATUS_NUM_DEF = 12;
    localparam int CAUSE_NUM_DEF  = 13;
    localparam int EPC_NUM_DEF    = 14;

    // Status fields
    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_LSB  = 8;
    localparam int STATUS_IM_MSB  = 15;
    localparam int IM_W           = STATUS_IM_MSB - STATUS_IM_LSB + 1;

    // Cause field: pending timer interrupt (IP7)
    localparam int CAUSE_IP7_BIT  = 15;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_STATUS,
        SEL_CAUSE,
        SEL_EPC
    } cp0_sel_e;

    // Map a register number onto the implemented register it selects.
    function automatic cp0_sel_e decode_reg(input logic [4:0] regnum,
                                            input logic [4:0] status_sel,
                                            input logic [4:0] cause_sel,
                                            input logic [4:0] epc_sel);
        if (regnum == status_sel)     return SEL_STATUS;
        else if (regnum == cause_sel) return SEL_CAUSE;
        else if (regnum == epc_sel)   return SEL_EPC;
        else                          return SEL_NONE;
    endfunction

endpackage

// File: rtl/cp0_register.sv
// cp0_register: W-bit register with load enable and asynchronous
// active-low clear.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset, clears o_q to 0
//   i_en    : load enable
//   i_d     : data loaded when i_en is high
//   o_q     : registered value
module cp0_register #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_q <= '0;
        else if (i_en)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/cp0.sv
// cp0: MIPS coprocessor-0 (Status, Cause, EPC) with timer interrupt
// detection.
//   rd_data        : out, combinational read of register selected by regnum
//   EPC            : out, saved exception PC (word address)
//   TakenInterrupt : out, combinational, interrupt taken this cycle
//   wr_data        : in,  MTC0 write data
//   regnum         : in,  register select for read and write
//   next_pc        : in,  word address saved to EPC on interrupt
//   MTC0           : in,  write enable for regnum
//   ERET           : in,  exception return, clears EXL
//   TimerInterrupt : in,  level timer interrupt request
//   clock          : in,  rising-edge clock
//   reset          : in,  asynchronous active-low reset
module cp0 #(
    parameter int width      = 64,
    parameter int status_num = 12,
    parameter int cause_num  = 13,
    parameter int epc_num    = 14
) (
    output logic [width-1:0] rd_data,
    output logic [width-3:0] EPC,
    output logic             TakenInterrupt,
    input  logic [width-1:0] wr_data,
    input  logic [4:0]       regnum,
    input  logic [width-3:0] next_pc,
    input  logic             MTC0,
    input  logic             ERET,
    input  logic             TimerInterrupt,
    input  logic             clock,
    input  logic             reset
);

    import cp0_pkg::*;

    localparam logic [4:0] STATUS_SEL = 5'(status_num);
    localparam logic [4:0] CAUSE_SEL  = 5'(cause_num);
    localparam logic [4:0] EPC_SEL    = 5'(epc_num);

    cp0_sel_e         w_sel;
    logic             w_status_we;
    logic             w_epc_we;
    logic             w_taken;
    logic [IM_W:0]    w_imie;      // {IM, IE}
    logic [IM_W-1:0]  w_im;
    logic             w_ie;
    logic [0:0]       w_exl;
    logic [width-3:0] w_epc;
    logic [width-3:0] w_epc_d;
    logic             w_unused;

    assign w_sel       = decode_reg(regnum, STATUS_SEL, CAUSE_SEL, EPC_SEL);
    assign w_status_we = MTC0 && (w_sel == SEL_STATUS);
    assign w_epc_we    = MTC0 && (w_sel == SEL_EPC);

    assign w_im = w_imie[IM_W:1];
    assign w_ie = w_imie[0];

    // EXL masks further interrupts, so this is high for at most one edge
    // per interrupt until ERET.
    assign w_taken        = TimerInterrupt & w_im[IM_W-1] & w_ie & ~w_exl[0];
    assign TakenInterrupt = w_taken;

    // Status bit 1 is the read-only EXL field; MTC0 does not load it.
    assign w_unused = wr_data[STATUS_EXL_BIT];

    cp0_register #(.W(IM_W + 1)) u_imie (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_en    (w_status_we),
        .i_d     ({wr_data[STATUS_IM_MSB:STATUS_IM_LSB], wr_data[STATUS_IE_BIT]}),
        .o_q     (w_imie)
    );

    // ERET has priority: loading ~ERET clears EXL even if an interrupt
    // is taken on the same edge.
    cp0_register #(.W(1)) u_exl (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_en    (ERET | w_taken),
        .i_d     (~ERET),
        .o_q     (w_exl)
    );

    // The interrupt's return address wins over a simultaneous MTC0.
    assign w_epc_d = w_taken ? next_pc : wr_data[width-1:2];

    cp0_register #(.W(width - 2)) u_epc (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_en    (w_taken | w_epc_we),
        .i_d     (w_epc_d),
        .o_q     (w_epc)
    );

    assign EPC = w_epc;

    always_comb begin
        rd_data = '0;
        case (w_sel)
            SEL_STATUS: begin
                rd_data[STATUS_IM_MSB:STATUS_IM_LSB] = w_im;
                rd_data[STATUS_EXL_BIT]              = w_exl[0];
                rd_data[STATUS_IE_BIT]               = w_ie;
            end
            // Cause reflects the live request, independent of reset.
            SEL_CAUSE: rd_data[CAUSE_IP7_BIT] = TimerInterrupt;
            SEL_EPC:   rd_data = {w_epc, 2'b00};
            default:   rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: directed scoreboard bench for cp0.
module tb_cp0;

    localparam int W = 64;

    logic [W-1:0] rd_data;
    logic [W-3:0] EPC;
    logic         TakenInterrupt;
    logic [W-1:0] wr_data;
    logic [4:0]   regnum;
    logic [W-3:0] next_pc;
    logic         MTC0;
    logic         ERET;
    logic         TimerInterrupt;
    logic         clock;
    logic         reset;

    cp0 #(.width(W), .status_num(12), .cause_num(13), .epc_num(14)) dut (
        .rd_data        (rd_data),
        .EPC            (EPC),
        .TakenInterrupt (TakenInterrupt),
        .wr_data        (wr_data),
        .regnum         (regnum),
        .next_pc        (next_pc),
        .MTC0           (MTC0),
        .ERET           (ERET),
        .TimerInterrupt (TimerInterrupt),
        .clock          (clock),
        .reset          (reset)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // kind: 0 = rd_data, 1 = EPC, 2 = TakenInterrupt
    typedef struct {
        int          kind;
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic push(input int kind, input string tag, input logic [63:0] v);
        exp_t e;
        e.kind = kind;
        e.tag  = tag;
        e.exp  = v;
        sbq.push_back(e);
    endtask

    // Let combinational outputs settle, then drain the scoreboard.
    task automatic check_out();
        exp_t        e;
        logic [63:0] obs;
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.kind)
                0:       obs = rd_data;
                1:       obs = 64'(EPC);
                default: obs = 64'(TakenInterrupt);
            endcase
            n_assert++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic read_chk(input logic [4:0] r, input string tag, input logic [63:0] v);
        regnum = r;
        push(0, tag, v);
        check_out();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [63:0] d);
        regnum  = r;
        wr_data = d;
        MTC0    = 1'b1;
        tick();
        MTC0    = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        wr_data        = '0;
        regnum         = 5'd0;
        next_pc        = '0;
        MTC0           = 1'b0;
        ERET           = 1'b0;
        TimerInterrupt = 1'b0;
        #3;

        // Reset state
        read_chk(5'd12, "rst_status", 64'h0);
        push(1, "rst_epc", 64'h0);
        push(2, "rst_taken", 64'h0);
        check_out();
        TimerInterrupt = 1'b1;
        read_chk(5'd13, "rst_cause_live", 64'h8000);
        TimerInterrupt = 1'b0;

        @(negedge clock);
        reset = 1'b1;
        tick();

        // Status write: EXL not writable
        mtc0(5'd12, 64'hffff_ffff);
        read_chk(5'd12, "status_wr", 64'h0000_ff01);
        push(2, "taken_idle", 64'h0);
        check_out();

        // Cause and unmapped writes ignored
        mtc0(5'd13, 64'hffff_ffff);
        read_chk(5'd13, "cause_ro", 64'h0);
        mtc0(5'd5, 64'hffff_ffff);
        read_chk(5'd5, "unmapped_rd", 64'h0);
        read_chk(5'd12, "status_after_unmapped", 64'h0000_ff01);
        push(1, "epc_after_unmapped", 64'h0);
        check_out();

        // Take an interrupt
        TimerInterrupt = 1'b1;
        next_pc        = 62'h100001;
        push(2, "taken_now", 64'h1);
        check_out();
        tick();
        push(1, "epc_saved", 64'h100001);
        push(2, "taken_masked_exl", 64'h0);
        check_out();
        next_pc = 62'h100002;
        tick();
        push(1, "epc_held", 64'h100001);
        check_out();
        read_chk(5'd12, "status_exl", 64'h0000_ff03);
        read_chk(5'd14, "epc_rd", 64'h400004);
        read_chk(5'd13, "cause_ip7", 64'h8000);

        // ERET
        TimerInterrupt = 1'b0;
        ERET           = 1'b1;
        tick();
        ERET = 1'b0;
        read_chk(5'd12, "status_eret", 64'h0000_ff01);
        read_chk(5'd13, "cause_clear", 64'h0);

        // EPC via MTC0
        mtc0(5'd14, 64'h1234);
        push(1, "epc_mtc0", 64'h48D);
        check_out();
        read_chk(5'd14, "epc_mtc0_rd", 64'h1234);

        // IE cleared: no interrupt
        mtc0(5'd12, 64'h0000_ff00);
        TimerInterrupt = 1'b1;
        push(2, "taken_ie0", 64'h0);
        check_out();
        tick();
        push(1, "epc_ie0", 64'h48D);
        check_out();
        read_chk(5'd12, "status_ie0", 64'h0000_ff00);

        // IM7 cleared: no interrupt
        mtc0(5'd12, 64'h0000_7f01);
        push(2, "taken_im0", 64'h0);
        check_out();
        tick();
        push(1, "epc_im0", 64'h48D);
        check_out();
        read_chk(5'd12, "status_im0", 64'h0000_7f01);

        // Interrupt beats simultaneous MTC0 to EPC
        mtc0(5'd12, 64'h0000_ff01);
        next_pc = 62'h777;
        regnum  = 5'd14;
        wr_data = 64'h4444;
        MTC0    = 1'b1;
        push(2, "taken_vs_mtc0", 64'h1);
        check_out();
        tick();
        MTC0 = 1'b0;
        push(1, "epc_irq_wins", 64'h777);
        check_out();

        // ERET beats a simultaneous taken interrupt
        ERET = 1'b1;
        tick();
        next_pc = 62'h555;
        push(2, "taken_after_eret", 64'h1);
        check_out();
        tick();
        ERET = 1'b0;
        read_chk(5'd12, "exl_eret_prio", 64'h0000_ff01);
        push(1, "epc_eret_irq", 64'h555);
        push(2, "taken_again", 64'h1);
        check_out();
        tick();
        read_chk(5'd12, "status_exl2", 64'h0000_ff03);

        // Asynchronous reset mid-run
        @(negedge clock);
        reset = 1'b0;
        read_chk(5'd12, "async_rst_status", 64'h0);
        push(1, "async_rst_epc", 64'h0);
        push(2, "async_rst_taken", 64'h0);
        check_out();
        read_chk(5'd13, "async_rst_cause", 64'h8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0.md
Name: cp0

Overview:
- MIPS coprocessor-0 (system control) block, sitting beside the CPU datapath.
- Holds Status, Cause and EPC registers and serves MFC0 reads and MTC0 writes.
- Detects a pending timer interrupt that is enabled and unmasked, and raises TakenInterrupt.
- On a taken interrupt it saves the return PC (word-aligned) and sets the exception level; ERET clears the exception level.

Parameters:
- width, 64, datapath width of rd_data/wr_data; EPC and next_pc are width-2 bits (word address).
- status_num, 12, register number of Status.
- cause_num, 13, register number of Cause.
- epc_num, 14, register number of EPC.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- rd_data  out  width  read value of register selected by regnum.
- EPC  out  width-2  current EPC register value (word address).
- TakenInterrupt  out  1  combinational; interrupt taken this cycle.
- wr_data  in  width  MTC0 write data.
- regnum  in  5  register select for read and write.
- next_pc  in  width-2  word address saved to EPC on interrupt.
- MTC0  in  1  write enable for register regnum.
- ERET  in  1  exception return; clears exception level.
- TimerInterrupt  in  1  level timer interrupt request.
- Declaration (positional) order: rd_data, EPC, TakenInterrupt, wr_data, regnum, next_pc, MTC0, ERET, TimerInterrupt, clock, reset.

Behaviour:
- State: IM[7:0] (Status bits 15:8), IE (Status bit 0), EXL (Status bit 1), EPC[width-3:0]. All are 0 while reset is low (asynchronous).
- Status read value: {zeros, IM at [15:8], zeros at [7:2], EXL at [1], IE at [0]}, zero-extended to width. All other bits always read 0.
- MTC0 && regnum==status_num at a clock edge: IM <= wr_data[15:8], IE <= wr_data[0]. EXL is not writable by MTC0, so writing 0xffffffff reads back 0x0000ff01.
- Cause read value: bit 15 = TimerInterrupt (live, unregistered); all other bits 0. Cause is not writable; an MTC0 to cause_num is ignored.
- TakenInterrupt = TimerInterrupt & IM[7] & IE & ~EXL. It is purely combinational, so it is 0 during reset.
- EXL: set to 1 at an edge where TakenInterrupt=1. Cleared at an edge where ERET=1. ERET has priority when both occur.
- TakenInterrupt is therefore high for at most one cycle per interrupt until ERET.
- EPC register update at a clock edge:
  - if TakenInterrupt: EPC <= next_pc;
  - else if MTC0 && regnum==epc_num: EPC <= wr_data[width-1:2].
  - The interrupt wins over a simultaneous MTC0.
  - While EXL=1 the interrupt is not taken, so EPC is not overwritten.
- EPC read value: rd_data = {EPC, 2'b00}.
- rd_data is a combinational mux on regnum. Any unmapped regnum reads 0.
- MTC0 to an unmapped regnum has no effect.
- Reset asserted mid-operation clears IM, IE, EXL and EPC immediately. Cause still reflects TimerInterrupt.
- Register writes and reads have zero-latency combinational read: a written value is visible on rd_data the cycle after the write edge.

Decomposition:
- Shared package (cp0_pkg):
  - default register-number constants 12/13/14;
  - Status bit positions (IE=0, EXL=1, IM=15:8) and Cause IP7 position (15).
- One natural sub-module, cp0_register: a parameterised-width register with enable, data and async active-low reset. Instantiate it for IM/IE, EXL and EPC.

Test Plan:
- Reset low, then released; MTC0=1, regnum=12, wr_data=0xffffffff for one edge; then MTC0=0 -> rd_data=0x0000ff01, TakenInterrupt=0.
- TimerInterrupt=1, next_pc=0x100001 -> TakenInterrupt=1 immediately. After the edge: EPC=0x100001 and TakenInterrupt=0. Change next_pc to 0x100002 -> EPC stays 0x100001; regnum=12 reads 0x0000ff03.
- regnum=14 -> rd_data=0x400004; regnum=13 with TimerInterrupt=1 -> rd_data=0x8000.
- TimerInterrupt=0, ERET=1 for one edge -> regnum=12 reads 0x0000ff01; regnum=13 reads 0.
- MTC0 regnum=14 wr_data=0x1234 -> EPC=0x48D, read 0x1234. Clear IE (write 0x0000ff00) or IM7 (write 0x00007f01) with TimerInterrupt=1 -> TakenInterrupt stays 0 and EPC is unchanged.
- Assert reset low mid-run after state is set -> Status reads 0, EPC=0 and TakenInterrupt=0 immediately, without a clock edge.
